band_trigger_sequencer: RTL

//  Trigger controller for an array of NCH band_pulse channels. Forms the masked

---
 rtl/band_trigger_sequencer_if.sv | 35 +++
 rtl/band_trigger_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/band_trigger_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : band_trigger_sequencer_if
// Purpose  : Bundle of channel-side inputs and trigger-side outputs shared
//            between the band trigger sequencer and whoever drives it.
// Revision : 1.0  initial release
// ============================================================================
interface band_trigger_sequencer_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]   antennaS;
  logic [NCH-1:0]   chan_en;
  logic [5:0]       threshold;
  logic             enable;
  logic [3:0]       trigger_shifter;
  logic             trig;
  logic             busy;
  logic [NCH-1:0]   hit_pattern;
  logic [CNT_W-1:0] trig_count;
  logic [CNT_W-1:0] drop_count;

  // Side that supplies hit lines and configuration
  modport master (
    output antennaS, chan_en, threshold, enable,
    input  trigger_shifter, trig, busy, hit_pattern, trig_count, drop_count
  );

  // Trigger sequencer side
  modport slave (
    input  antennaS, chan_en, threshold, enable,
    output trigger_shifter, trig, busy, hit_pattern, trig_count, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/band_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : band_trigger_sequencer
// Purpose  : Masked coincidence trigger for NCH band_pulse channels. Drives
//            the freeze/latch step sequence, enforces a holdoff and keeps
//            accepted-trigger and dropped-coincidence counters.
// Revision : 1.0  initial release
// ============================================================================
module band_trigger_sequencer #(
  parameter int NCH     = 8,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  wire logic              clk_r2,
  input  wire logic              reset,
  band_trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Holdoff counter load value: counting HOLDOFF-1 down to 0 spans HOLDOFF cycles
  localparam logic [7:0]       c_hold_load = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [2:0]       c_last_step = 3'd5;

  // Stage 1 registers
  logic [NCH-1:0]   w_masked;
  logic [5:0]       w_pop;
  logic [5:0]       r_pop;
  logic [NCH-1:0]   r_hit;

  // Sequencer state and its next-state values
  state_t           r_state,    w_state;
  logic [2:0]       r_shift,    w_shift;
  logic             r_trig,     w_trig;
  logic             r_busy,     w_busy;
  logic [NCH-1:0]   r_hit_pat,  w_hit_pat;
  logic [CNT_W-1:0] r_trig_cnt, w_trig_cnt;
  logic [CNT_W-1:0] r_drop_cnt, w_drop_cnt;
  logic [7:0]       r_hold,     w_hold;
  logic             w_coin;

  assign w_masked = bus.antennaS & bus.chan_en;

  // Count enabled channels currently reporting a hit
  always_comb begin
    w_pop = 6'd0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + {5'd0, w_masked[i]};
    end
  end

  // Register coincidence population and masked hit lines
  always_ff @(posedge clk_r2) begin
    if (reset) begin
      r_pop <= 6'd0;
      r_hit <= '0;
    end else begin
      r_pop <= w_pop;
      r_hit <= w_masked;
    end
  end

  // A zero threshold disables triggering entirely
  assign w_coin = (bus.threshold != 6'd0) && (r_pop >= bus.threshold);

  // Sequencer state register
  always_ff @(posedge clk_r2) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= 3'd0;
      r_trig     <= 1'b0;
      r_busy     <= 1'b0;
      r_hit_pat  <= '0;
      r_trig_cnt <= '0;
      r_drop_cnt <= '0;
      r_hold     <= 8'd0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_trig     <= w_trig;
      r_busy     <= w_busy;
      r_hit_pat  <= w_hit_pat;
      r_trig_cnt <= w_trig_cnt;
      r_drop_cnt <= w_drop_cnt;
      r_hold     <= w_hold;
    end
  end

  // Next-state, step sequence, counters
  always_comb begin
    w_state    = r_state;
    w_shift    = 3'd0;
    w_trig     = 1'b0;
    w_hit_pat  = r_hit_pat;
    w_trig_cnt = r_trig_cnt;
    w_drop_cnt = r_drop_cnt;
    w_hold     = r_hold;

    case (r_state)
      ST_IDLE: begin
        if (w_coin && bus.enable) begin
          w_state    = ST_FREEZE;
          w_shift    = 3'd1;
          w_trig     = 1'b1;
          w_hit_pat  = r_hit;
          w_trig_cnt = r_trig_cnt + 1'b1;
        end
      end
      ST_FREEZE: begin
        if (r_shift < c_last_step) begin
          w_shift = r_shift + 3'd1;
        end else if (HOLDOFF == 0) begin
          w_state = ST_IDLE;
        end else begin
          w_state = ST_HOLDOFF;
          w_hold  = c_hold_load;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold == 8'd0) begin
          w_state = ST_IDLE;
        end else begin
          w_hold = r_hold - 8'd1;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Any coincidence that cannot start a trigger is counted as dropped
    if (w_coin && ((r_state != ST_IDLE) || !bus.enable) && (r_drop_cnt != c_cnt_max)) begin
      w_drop_cnt = r_drop_cnt + 1'b1;
    end

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.trigger_shifter = {1'b0, r_shift};
  assign bus.trig            = r_trig;
  assign bus.busy            = r_busy;
  assign bus.hit_pattern     = r_hit_pat;
  assign bus.trig_count      = r_trig_cnt;
  assign bus.drop_count      = r_drop_cnt;

endmodule
`default_nettype wire
